// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code image and a one-cycle boundary pulse.
// Build option GRAY_COUNTER_SAT_EN: saturate at the limits; wrap then flags a blocked step.
module gray_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ResetBin  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ResetGray = ResetBin ^ (ResetBin >> 1);
  localparam logic [WIDTH-1:0] MaxVal    = '1;
  localparam logic [WIDTH-1:0] MinVal    = '0;
  localparam logic [WIDTH-1:0] One       = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_min;

  assign at_max = (bin_q == MaxVal);
  assign at_min = (bin_q == MinVal);

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (up_dn) begin
`ifdef GRAY_COUNTER_SAT_EN
        if (at_max) begin
          wrap_d = 1'b1;
        end else begin
          bin_d = bin_q + One;
        end
`else
        bin_d  = bin_q + One;
        wrap_d = at_max;
`endif
      end else begin
`ifdef GRAY_COUNTER_SAT_EN
        if (at_min) begin
          wrap_d = 1'b1;
        end else begin
          bin_d = bin_q - One;
        end
`else
        bin_d  = bin_q - One;
        wrap_d = at_min;
`endif
      end
    end
    // Gray is derived from the next binary value so both land on the same edge.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= ResetBin;
      gray_q <= ResetGray;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign wrap = wrap_q;

endmodule
